// File: rtl/wrap030_bus_pkg.sv
// Shared types for the Wrap030 bus initiator: FSM states, responder port
// widths, SIZ encodings and the DSACK1:0 decode.
package wrap030_bus_pkg;

    typedef enum logic [2:0] {
        S_IDL = 3'd0,
        S_ADR = 3'd1,
        S_STB = 3'd2,
        S_WAT = 3'd3,
        S_TRM = 3'd4,
        S_REC = 3'd5,
        S_RSP = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        PORT_32   = 2'd0,
        PORT_16   = 2'd1,
        PORT_8    = 2'd2,
        PORT_NONE = 2'd3
    } port_t;

    localparam logic [1:0] SIZ_LONG  = 2'b00;
    localparam logic [1:0] SIZ_BYTE  = 2'b01;
    localparam logic [1:0] SIZ_WORD  = 2'b10;
    localparam logic [1:0] SIZ_3BYTE = 2'b11;

    // DSACK1:0 are active-low; both negated means no acknowledge yet.
    function automatic port_t decode_dsack(input logic [1:0] dsack_n);
        case (dsack_n)
            2'b00:   return PORT_32;
            2'b01:   return PORT_16;
            2'b10:   return PORT_8;
            default: return PORT_NONE;
        endcase
    endfunction

    function automatic logic [2:0] siz_bytes(input logic [1:0] siz);
        return (siz == SIZ_LONG) ? 3'd4 : {1'b0, siz};
    endfunction

endpackage

// File: rtl/wrap030_bus_lanes.sv
// Byte-lane datapath for one bus cycle: bytes taken per port width, write
// lane steering from the left-justified shift register, read accumulation.
module wrap030_bus_lanes
    import wrap030_bus_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  cnt,
    input  logic [1:0]  port,
    input  logic [31:0] wshift,
    input  logic [31:0] rdata,
    input  logic [31:0] acc,
    output logic [2:0]  take_n,
    output logic [31:0] lane_wdata,
    output logic [31:0] acc_next
);

    logic [1:0]  start_lane;
    logic [2:0]  room;
    logic [31:0] taken;
    logic [7:0]  rd_byte [4];

    // Which byte of the shift register (0 = MSB) a lane carries, so that every
    // port width finds the next operand byte on the lanes it actually samples.
    function automatic logic [1:0] byte_index(input logic [1:0] lane, input logic [1:0] a);
        if (lane >= a) begin
            return lane - a;
        end else if (lane[0] >= a[0]) begin
            return {1'b0, lane[0] - a[0]};
        end else begin
            return 2'd0;
        end
    endfunction

    always_comb begin
        start_lane = 2'd0;
        room       = 3'd1;
        case (port_t'(port))
            PORT_32: begin
                start_lane = addr_lo;
                room       = 3'd4 - {1'b0, addr_lo};
            end
            PORT_16: begin
                start_lane = {1'b0, addr_lo[0]};
                room       = 3'd2 - {2'b00, addr_lo[0]};
            end
            default: begin
                start_lane = 2'd0;
                room       = 3'd1;
            end
        endcase
        take_n = (cnt < room) ? cnt : room;
    end

    for (genvar l = 0; l < 4; l++) begin : g_lane
        logic [1:0] k;
        assign k = byte_index(2'(l), addr_lo);
        assign lane_wdata[31-8*l -: 8] = wshift[31-8*k -: 8];
        assign rd_byte[l] = rdata[31-8*l -: 8];
    end

    // Lane 0 is D31:24, so taking lanes in ascending order yields big-endian bytes.
    always_comb begin
        taken = '0;
        for (int i = 0; i < 4; i++) begin
            if (3'(i) < take_n) begin
                taken = {taken[23:0], rd_byte[start_lane + 2'(i)]};
            end
        end
        acc_next = (acc << {take_n, 3'b000}) | taken;
    end

endmodule

// File: rtl/wrap030_bus_master.sv
// Wrap030 bus initiator: runs one operand transfer at a time as a sequence of
// AS/DS bus cycles, resized on the fly from the responder's DSACK1:0.
module wrap030_bus_master
    import wrap030_bus_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        busClk,
    input  logic        busReset,
    input  logic        reqValid,
    output logic        reqReady,
    input  logic [31:0] reqAddr,
    input  logic        reqRW_n,
    input  logic [1:0]  reqSize,
    input  logic [2:0]  reqFC,
    input  logic [31:0] reqWData,
    output logic        rspValid,
    output logic [31:0] rspRData,
    output logic        rspBerr,
    output logic [31:0] busAddr,
    output logic [2:0]  busFC,
    output logic [1:0]  busSiz,
    output logic        busRW_n,
    output logic        busAS_n,
    output logic        busDS_n,
    output logic [31:0] busDataOut,
    output logic        busDataOE,
    input  logic [31:0] busDataIn,
    input  logic [1:0]  busDsack_n,
    input  logic        busBerr_n,
    output logic [2:0]  fsm_state
);

    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    state_t        state, next_state;
    logic          ready_q;
    logic [31:0]   addr_q;
    logic [2:0]    cnt_q;
    logic [31:0]   wshift_q;
    logic [31:0]   acc_q;
    logic          rw_q;
    logic [2:0]    fc_q;
    logic          err_q;
    port_t         port_q;
    logic [TW-1:0] timer_q;
    logic [31:0]   rsp_data_q;
    logic          rsp_berr_q;

    port_t         dsack_port;
    logic [2:0]    take_n;
    logic [31:0]   lane_wdata;
    logic [31:0]   acc_next;
    logic          in_cycle;

    assign dsack_port = decode_dsack(busDsack_n);

    wrap030_bus_lanes u_lanes (
        .addr_lo    (addr_q[1:0]),
        .cnt        (cnt_q),
        .port       (port_q),
        .wshift     (wshift_q),
        .rdata      (busDataIn),
        .acc        (acc_q),
        .take_n     (take_n),
        .lane_wdata (lane_wdata),
        .acc_next   (acc_next)
    );

    // Request handshake: a transfer is taken on the edge where reqValid and
    // reqReady are both high; reqReady is registered and only high in S_IDL.
    always_comb begin
        next_state = state;
        in_cycle   = 1'b0;
        rspValid   = 1'b0;
        busAS_n    = 1'b1;
        busDS_n    = 1'b1;
        case (state)
            S_IDL: begin
                if (reqValid && ready_q) next_state = S_ADR;
            end
            S_ADR: begin
                in_cycle   = 1'b1;
                next_state = S_STB;
            end
            S_STB: begin
                in_cycle   = 1'b1;
                busAS_n    = 1'b0;
                busDS_n    = !rw_q;
                next_state = S_WAT;
            end
            S_WAT: begin
                in_cycle = 1'b1;
                busAS_n  = 1'b0;
                busDS_n  = 1'b0;
                if (!busBerr_n || dsack_port != PORT_NONE || timer_q == TIMER_LAST) begin
                    next_state = S_TRM;
                end
            end
            S_TRM: begin
                in_cycle   = 1'b1;
                next_state = S_REC;
            end
            S_REC: begin
                // Wait for the responder to release its terminations first.
                if (busDsack_n == 2'b11 && busBerr_n) begin
                    next_state = (cnt_q != 3'd0 && !err_q) ? S_ADR : S_RSP;
                end
            end
            S_RSP: begin
                rspValid   = 1'b1;
                next_state = S_IDL;
            end
            default: next_state = S_IDL;
        endcase
    end

    always_ff @(posedge busClk) begin
        if (busReset) begin
            state      <= S_IDL;
            ready_q    <= 1'b0;
            addr_q     <= '0;
            cnt_q      <= '0;
            wshift_q   <= '0;
            acc_q      <= '0;
            rw_q       <= 1'b1;
            fc_q       <= '0;
            err_q      <= 1'b0;
            port_q     <= PORT_NONE;
            timer_q    <= '0;
            rsp_data_q <= '0;
            rsp_berr_q <= 1'b0;
        end else begin
            state   <= next_state;
            ready_q <= (next_state == S_IDL);
            case (state)
                S_IDL: begin
                    if (reqValid && ready_q) begin
                        addr_q   <= reqAddr;
                        cnt_q    <= siz_bytes(reqSize);
                        wshift_q <= reqWData << {3'd4 - siz_bytes(reqSize), 3'b000};
                        acc_q    <= '0;
                        rw_q     <= reqRW_n;
                        fc_q     <= reqFC;
                        err_q    <= 1'b0;
                    end
                end
                S_STB: timer_q <= '0;
                S_WAT: begin
                    if (!busBerr_n) begin
                        err_q <= 1'b1;
                    end else if (dsack_port != PORT_NONE) begin
                        port_q <= dsack_port;
                    end else if (timer_q == TIMER_LAST) begin
                        err_q <= 1'b1;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                S_TRM: begin
                    if (!err_q) begin
                        acc_q    <= acc_next;
                        addr_q   <= addr_q + 32'(take_n);
                        cnt_q    <= cnt_q - take_n;
                        wshift_q <= wshift_q << {take_n, 3'b000};
                    end
                end
                S_REC: begin
                    if (next_state == S_RSP) begin
                        rsp_data_q <= (err_q || !rw_q) ? '0 : acc_q;
                        rsp_berr_q <= err_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign reqReady   = ready_q;
    assign rspRData   = rsp_data_q;
    assign rspBerr    = rsp_berr_q;
    assign busAddr    = addr_q;
    assign busFC      = fc_q;
    assign busSiz     = cnt_q[1:0];
    assign busRW_n    = in_cycle ? rw_q : 1'b1;
    assign busDataOE  = in_cycle && !rw_q;
    assign busDataOut = lane_wdata;
    assign fsm_state  = state;

endmodule

// File: tb/tb_wrap030_bus_master.sv
// Bench for wrap030_bus_master: a byte-memory responder of selectable port
// width answers each bus cycle; results are compared with a transfer-level model.
module tb_wrap030_bus_master;

    localparam int TMO = 20;

    logic        busClk = 1'b0;
    logic        busReset;
    logic        reqValid;
    logic        reqReady;
    logic [31:0] reqAddr;
    logic        reqRW_n;
    logic [1:0]  reqSize;
    logic [2:0]  reqFC;
    logic [31:0] reqWData;
    logic        rspValid;
    logic [31:0] rspRData;
    logic        rspBerr;
    logic [31:0] busAddr;
    logic [2:0]  busFC;
    logic [1:0]  busSiz;
    logic        busRW_n;
    logic        busAS_n;
    logic        busDS_n;
    logic [31:0] busDataOut;
    logic        busDataOE;
    logic [31:0] busDataIn;
    logic [1:0]  busDsack_n;
    logic        busBerr_n;
    logic [2:0]  fsm_state;

    wrap030_bus_master #(.TIMEOUT(TMO)) dut (
        .busClk     (busClk),
        .busReset   (busReset),
        .reqValid   (reqValid),
        .reqReady   (reqReady),
        .reqAddr    (reqAddr),
        .reqRW_n    (reqRW_n),
        .reqSize    (reqSize),
        .reqFC      (reqFC),
        .reqWData   (reqWData),
        .rspValid   (rspValid),
        .rspRData   (rspRData),
        .rspBerr    (rspBerr),
        .busAddr    (busAddr),
        .busFC      (busFC),
        .busSiz     (busSiz),
        .busRW_n    (busRW_n),
        .busAS_n    (busAS_n),
        .busDS_n    (busDS_n),
        .busDataOut (busDataOut),
        .busDataOE  (busDataOE),
        .busDataIn  (busDataIn),
        .busDsack_n (busDsack_n),
        .busBerr_n  (busBerr_n),
        .fsm_state  (fsm_state)
    );

    always #5 busClk = ~busClk;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] exp_q [$];

    // Responder memory, indexed by the low address byte.
    logic [7:0]  mem [256];
    int          resp_width;
    int          berr_at;
    int          cyc_n;
    logic        ack_on;
    logic [31:0] cyc_addr  [16];
    logic [1:0]  cyc_siz   [16];
    logic [2:0]  cyc_fc    [16];
    logic        cyc_rw    [16];
    logic [7:0]  cyc_lane0 [16];

    logic [31:0] last_rdata;
    int          last_edges;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a, input int nb);
        logic [31:0] w;
        w = '0;
        for (int i = 0; i < nb; i++) w = {w[23:0], mem[8'(a + 32'(i))]};
        return w;
    endfunction

    task automatic serve_cycle();
        int          pw;
        int          off;
        int          n;
        int          sizb;
        logic [31:0] a;
        logic [31:0] d;
        a    = busAddr;
        sizb = (busSiz == 2'b00) ? 4 : int'(busSiz);
        pw   = (resp_width == 0) ? 4 : resp_width / 8;
        off  = int'(a[1:0]) % pw;
        n    = (sizb < pw - off) ? sizb : pw - off;
        if (busRW_n) begin
            d = $urandom;
            for (int l = 0; l < pw; l++) d[31-8*l -: 8] = mem[8'(a - 32'(off) + 32'(l))];
            busDataIn = d;
        end else if (resp_width != 0 && cyc_n != berr_at) begin
            for (int i = 0; i < n; i++) mem[8'(a + 32'(i))] = busDataOut[31-8*(off+i) -: 8];
        end
        if (cyc_n == berr_at) begin
            busBerr_n = 1'b0;
        end else begin
            case (resp_width)
                32:      busDsack_n = 2'b00;
                16:      busDsack_n = 2'b01;
                8:       busDsack_n = 2'b10;
                default: busDsack_n = 2'b11;
            endcase
        end
    endtask

    // Responder reacts on the falling edge so the DUT samples settled inputs.
    initial begin : responder
        busDsack_n = 2'b11;
        busBerr_n  = 1'b1;
        busDataIn  = '0;
        ack_on     = 1'b0;
        forever begin
            @(negedge busClk);
            if (!busAS_n && !ack_on) begin
                ack_on = 1'b1;
                if (cyc_n < 16) begin
                    cyc_addr[cyc_n]  = busAddr;
                    cyc_siz[cyc_n]   = busSiz;
                    cyc_fc[cyc_n]    = busFC;
                    cyc_rw[cyc_n]    = busRW_n;
                    cyc_lane0[cyc_n] = busDataOut[31:24];
                end
                cyc_n++;
                serve_cycle();
            end else if (busAS_n && ack_on) begin
                ack_on     = 1'b0;
                busDsack_n = 2'b11;
                busBerr_n  = 1'b1;
            end
        end
    end

    task automatic do_xfer(input logic [31:0] addr, input logic rw_n, input logic [1:0] siz,
                           input logic [2:0] fc, input logic [31:0] wdata, input int width,
                           input int berr_cyc, output logic [31:0] rdata, output logic berr,
                           output int edges);
        int guard;
        resp_width = width;
        berr_at    = berr_cyc;
        cyc_n      = 0;
        @(negedge busClk);
        reqValid = 1'b1;
        reqAddr  = addr;
        reqRW_n  = rw_n;
        reqSize  = siz;
        reqFC    = fc;
        reqWData = wdata;
        guard    = 0;
        while (!reqReady && guard < 20) begin
            @(negedge busClk);
            guard++;
        end
        check("req_ready", reqReady, 1'b1);
        @(negedge busClk);
        reqValid = 1'b0;
        // edges = number of rising edges after accept up to the one sampling rspValid
        edges = 1;
        while (!rspValid && edges < 400) begin
            @(negedge busClk);
            edges++;
        end
        check("rsp_arrives", rspValid, 1'b1);
        rdata = rspRData;
        berr  = rspBerr;
    endtask

    task automatic run_xfer(input logic [31:0] addr, input logic rw_n, input logic [1:0] siz,
                            input logic [2:0] fc, input logic [31:0] wdata, input int width,
                            input int berr_cyc);
        int          sizb, rem, n, pw, ncyc, edges;
        logic [31:0] a, got, mask;
        logic [31:0] ea [16];
        logic [1:0]  es [16];
        logic        berr;
        logic        expect_err;
        sizb = (siz == 2'b00) ? 4 : int'(siz);
        rem  = sizb;
        a    = addr;
        ncyc = 0;
        expect_err = 1'b0;
        while (rem > 0 && ncyc < 16) begin
            ea[ncyc] = a;
            es[ncyc] = 2'(rem);
            ncyc++;
            if (width == 0 || berr_cyc == ncyc) begin
                expect_err = 1'b1;
                break;
            end
            pw = width / 8;
            n  = pw - (int'(a[1:0]) % pw);
            if (n > rem) n = rem;
            a   = a + 32'(n);
            rem = rem - n;
        end
        exp_q.push_back((rw_n && !expect_err) ? mem_word(addr, sizb) : 32'h0);
        do_xfer(addr, rw_n, siz, fc, wdata, width, berr_cyc, got, berr, edges);
        last_rdata = got;
        last_edges = edges;
        check("rsp_berr", berr, expect_err);
        check("rsp_rdata", got, exp_q.pop_front());
        check("latency", edges, (width == 0) ? 5 + TMO : 5 * ncyc + 1);
        check("bus_cycles", cyc_n, ncyc);
        for (int k = 0; k < ncyc && k < cyc_n && k < 16; k++) begin
            check($sformatf("cyc%0d_addr", k), cyc_addr[k], ea[k]);
            check($sformatf("cyc%0d_siz", k), cyc_siz[k], es[k]);
            check($sformatf("cyc%0d_fc", k), cyc_fc[k], fc);
            check($sformatf("cyc%0d_rw", k), cyc_rw[k], rw_n);
        end
        if (!rw_n && !expect_err) begin
            mask = 32'hFFFF_FFFF >> (8 * (4 - sizb));
            check("write_mem", mem_word(addr, sizb), wdata & mask);
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int  guard;
        bit  saw_rsp;
        busReset = 1'b1;
        reqValid = 1'b0;
        reqAddr  = '0;
        reqRW_n  = 1'b1;
        reqSize  = 2'b00;
        reqFC    = '0;
        reqWData = '0;
        resp_width = 32;
        berr_at    = 0;
        cyc_n      = 0;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);

        repeat (3) @(negedge busClk);
        check("rst_req_ready", reqReady, 1'b0);
        check("rst_rsp_valid", rspValid, 1'b0);
        check("rst_rsp_berr", rspBerr, 1'b0);
        check("rst_as", busAS_n, 1'b1);
        check("rst_ds", busDS_n, 1'b1);
        check("rst_rw", busRW_n, 1'b1);
        check("rst_oe", busDataOE, 1'b0);
        check("rst_addr", busAddr, 32'h0);
        check("rst_fc", busFC, 3'h0);
        check("rst_siz", busSiz, 2'b00);
        check("rst_dout", busDataOut, 32'h0);
        check("rst_rdata", rspRData, 32'h0);
        busReset = 1'b0;
        @(negedge busClk);
        check("idle_ready", reqReady, 1'b1);

        // aligned long read from a 32-bit port
        mem[8'h00] = 8'h11; mem[8'h01] = 8'h22; mem[8'h02] = 8'h33; mem[8'h03] = 8'h44;
        run_xfer(32'h0000_1000, 1'b1, 2'b00, 3'd5, 32'h0, 32, 0);
        check("long_read_data", last_rdata, 32'h1122_3344);
        check("long_read_lat", last_edges, 6);
        check("idle_oe", busDataOE, 1'b0);
        check("idle_rw", busRW_n, 1'b1);

        // long write to an 8-bit port: operand bytes all appear on lane 0
        run_xfer(32'h0000_1000, 1'b0, 2'b00, 3'd1, 32'hAABB_CCDD, 8, 0);
        check("wr8_lane0_c0", cyc_lane0[0], 8'hAA);
        check("wr8_lane0_c1", cyc_lane0[1], 8'hBB);
        check("wr8_lane0_c2", cyc_lane0[2], 8'hCC);
        check("wr8_lane0_c3", cyc_lane0[3], 8'hDD);

        // misaligned word read crossing a long boundary
        mem[8'h03] = 8'h5A; mem[8'h04] = 8'hA5;
        run_xfer(32'h0000_1003, 1'b1, 2'b10, 3'd2, 32'h0, 32, 0);
        check("mis_word_data", last_rdata, 32'h0000_5AA5);

        // word read from a 16-bit port, one cycle
        mem[8'h02] = 8'h12; mem[8'h03] = 8'h34;
        run_xfer(32'h0000_2002, 1'b1, 2'b10, 3'd6, 32'h0, 16, 0);
        check("w16_data", last_rdata, 32'h0000_1234);

        // BERR on the second cycle of a three-cycle long read
        run_xfer(32'h0000_3001, 1'b1, 2'b00, 3'd5, 32'h0, 16, 2);
        check("berr_data", last_rdata, 32'h0);

        // silent bus: timeout ends the transfer with an error
        run_xfer(32'h0000_4000, 1'b1, 2'b00, 3'd5, 32'h0, 0, 0);

        // reset while waiting for a termination drops the transfer
        resp_width = 0;
        berr_at    = 0;
        cyc_n      = 0;
        @(negedge busClk);
        reqValid = 1'b1;
        reqAddr  = 32'h0000_5000;
        reqRW_n  = 1'b1;
        reqSize  = 2'b00;
        guard = 0;
        while (!reqReady && guard < 20) begin
            @(negedge busClk);
            guard++;
        end
        @(negedge busClk);
        reqValid = 1'b0;
        guard = 0;
        while (!(busAS_n == 1'b0 && busDS_n == 1'b0) && guard < 10) begin
            @(negedge busClk);
            guard++;
        end
        @(negedge busClk);
        check("wait_strobes", {busAS_n, busDS_n}, 2'b00);
        busReset = 1'b1;
        @(negedge busClk);
        check("mid_rst_as", busAS_n, 1'b1);
        check("mid_rst_ds", busDS_n, 1'b1);
        check("mid_rst_rw", busRW_n, 1'b1);
        check("mid_rst_ready", reqReady, 1'b0);
        busReset = 1'b0;
        saw_rsp  = 1'b0;
        repeat (TMO + 10) begin
            @(negedge busClk);
            if (rspValid) saw_rsp = 1'b1;
        end
        check("mid_rst_no_rsp", saw_rsp, 1'b0);

        run_xfer(32'h0000_6004, 1'b1, 2'b00, 3'd3, 32'h0, 32, 0);

        for (int t = 0; t < 40; t++) begin
            int w;
            int bc;
            case ($urandom_range(0, 2))
                0:       w = 32;
                1:       w = 16;
                default: w = 8;
            endcase
            bc = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 3)) : 0;
            run_xfer($urandom, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                     3'($urandom_range(0, 7)), $urandom, w, bc);
        end

        repeat (2) @(negedge busClk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/wrap030_bus_master.md
# wrap030_bus_master

Synchronous MC68030-style bus initiator for the Wrap030 expansion bus, the counterpart of the DRAM/peripheral responders on that bus. It accepts one operand-transfer request at a time (1–4 bytes, any alignment) from a local engine such as a DMA or test engine. It sequences AS/DS/SIZ/R/W cycles and applies dynamic bus sizing from DSACK1:0, splitting a transfer into as many bus cycles as the responding port width requires. It returns assembled read data or an error.

## Interface
- `TIMEOUT`, default 255: maximum `sWAT` cycles before forced error termination.
- `busClk` in 1: bus clock; all logic on its rising edge.
- `busReset` in 1: reset, synchronous, active-high.
- `reqValid` in 1: request present.
- `reqReady` out 1: request accepted when `reqValid && reqReady`.
- `reqAddr` in 32: operand start address.
- `reqRW_n` in 1: 1 = read, 0 = write.
- `reqSize` in 2: SIZ encoding; 00 = 4 bytes, 01 = 1, 10 = 2, 11 = 3.
- `reqFC` in 3: function code for all cycles of the transfer.
- `reqWData` in 32: write operand, right-justified.
- `rspValid` out 1: one-cycle completion pulse.
- `rspRData` out 32: read operand, right-justified, zero-filled; 0 on error or write.
- `rspBerr` out 1: qualified by `rspValid`; transfer ended by BERR or timeout.
- `busAddr` out 32 / `busFC` out 3 / `busSiz` out 2 / `busRW_n` out 1: current bus cycle.
- `busAS_n`, `busDS_n` out 1: address and data strobes, active-low.
- `busDataOut` out 32 / `busDataOE` out 1: write data and its drive enable.
- `busDataIn` in 32: read data; lane 0 = D31:24.
- `busDsack_n` in 2: data-strobe acknowledge, active-low.
- `busBerr_n` in 1: bus error, active-low.

## Operation
- Inputs are sampled raw; synchronizers are external. There are no input-to-output combinational paths.
- **Reset values:**
  - `reqReady`, `rspValid`, `rspBerr`, `busDataOE` = 0.
  - `busAS_n`, `busDS_n`, `busRW_n` = 1.
  - `busAddr`, `busFC`, `busSiz`, `busDataOut`, `rspRData` = 0.
  - State = `sIDL`.
- **Reset mid-cycle:** strobes negate on the next edge; the transfer is dropped with no response.
- **Registers:**
  - current address `A` (32 bit).
  - remaining count `cnt` (3 bit, 1–4).
  - write shift register `R`: left-justified, zero-filled, shifted left 8·n after each cycle.
  - read accumulator `acc`: cleared on accept; `acc = (acc << 8n) | taken bytes`.
- **Port width from DSACK1:0 (active-low):**
  - 00 → 32-bit port: start lane `s = A[1:0]`, n = min(`cnt`, 4 − `A[1:0]`).
  - 01 → 16-bit port: `s = A[0]`, n = min(`cnt`, 2 − `A[0]`).
  - 10 → 8-bit port: `s = 0`, n = 1.
  - A read takes lanes s..s+n−1.
- **After each cycle:** `A += n`; `cnt −= n`. `busSiz = cnt[1:0]`, so `cnt` = 4 drives 00.
- **Write lane steering:** lane L drives byte index k of `R`, k = 0 being the MSB. Rules:
  - If L ≥ `A[1:0]`: k = L − `A[1:0]`.
  - Else if `L[0]` ≥ `A[0]`: k = `L[0]` − `A[0]`.
  - Else: k = 0.
- **BERR** has priority over DSACK when both are sampled in the same `sWAT` cycle.

## Timing
- **States:** `sIDL`, `sADR`, `sSTB`, `sWAT`, `sTRM`, `sREC`, `sRSP`.
- **Transitions:**
  - `sIDL`: `reqReady` = 1; on accept → `sADR`.
  - `sADR`: drive `busAddr`/`busFC`/`busSiz`/`busRW_n`; `busDataOE` asserted for writes (`sADR` through `sTRM`); strobes negated → `sSTB`.
  - `sSTB`: `busAS_n` = 0; `busDS_n` = 0 if read → `sWAT`.
  - `sWAT`: AS and DS asserted; timeout counter increments.
    - BERR sampled → `sTRM` with error.
    - DSACK sampled → `sTRM` with the port width.
    - Counter reaches `TIMEOUT` → `sTRM` with error.
  - `sTRM`: strobes negated; data latched, counters updated → `sREC`.
  - `sREC`: held until `busDsack_n` = 11 and `busBerr_n` = 1.
    - Then → `sADR` if `cnt` > 0 and no error; else → `sRSP`.
  - `sRSP`: `rspValid` = 1 for one cycle → `sIDL`.
- **Minimum latency:** aligned 32-bit transfer with immediate DSACK gives `rspValid` 6 cycles after accept. Each extra bus cycle adds 5.
- **Bus cycle boundaries:** `busRW_n` = 1 and `busDataOE` = 0 outside `sADR`..`sTRM`.

## Structure
- **Package `wrap030_bus_pkg`:**
  - state enum.
  - port-width enum (P32/P16/P8).
  - SIZ constants.
  - DSACK decode function.
- **Sub-module `wrap030_bus_lanes`:** combinational write steering, start lane/n computation, read byte extraction.

## Test plan
- **Aligned long read, 32-bit port:** read 0x00001000, size 00, DSACK = 00, data 0x11223344.
  - Required: one cycle, SIZ = 00, `rspRData` = 0x11223344, `rspValid` at accept + 6.
- **Long write, 8-bit port:** write 0xAABBCCDD to 0x1000, DSACK = 10.
  - Required: 4 cycles at 0x1000–0x1003, SIZ 00/11/10/01, lane 0 = AA/BB/CC/DD.
- **Misaligned word read, 32-bit port:** read at 0x1003, size 10.
  - Required: cycle 1 takes lane 3 at 0x1003, cycle 2 takes lane 0 at 0x1004; `rspRData` = 0x0000XXYY in order.
- **Word read, 16-bit port:** read at 0x2002, DSACK = 01.
  - Required: single cycle, lanes 0–1, no continuation.
- **BERR on continuation:** BERR on the second cycle of a 16-bit-port long read.
  - Required: no third cycle, `rspBerr` = 1, `rspRData` = 0.
- **Timeout, then reset:** no DSACK.
  - Required: `rspBerr` after `TIMEOUT` wait cycles.
  - Then `busReset` asserted in `sWAT`: AS/DS negate next edge, no `rspValid`.
